edge_event_arbiter: RTL and testbench

EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

---
 rtl/edge_arb_pkg.sv | 11 +
 rtl/edge_pulse.sv | 26 ++
 rtl/edge_event_arbiter.sv | 109 ++++++++++
 tb/tb_edge_event_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/edge_arb_pkg.sv
// Shared types and defaults for the edge-event arbiter.
package edge_arb_pkg;

  localparam int N_CH_DEF = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/edge_pulse.sv
// Single-channel rise detector: one registered tick per 0->1 transition of level.
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic tick
);

  // seen_low_q starts cleared, so a level already high at reset release
  // cannot fire until it has been observed low at least once.
  logic seen_low_q;
  logic tick_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seen_low_q <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      tick_q     <= level & seen_low_q;
      seen_low_q <= ~level;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/edge_event_arbiter.sv
// Rise-event capture per channel with round-robin offer on a valid/ready port.
module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N_CH = N_CH_DEF,
  parameter int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] level,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [ID_W-1:0] ev_id,
  output logic [N_CH-1:0] overflow,
  input  logic [N_CH-1:0] ovf_clr
);

  logic [N_CH-1:0] tick;

  for (genvar g = 0; g < N_CH; g++) begin : g_edge
    edge_pulse u_edge (
      .clk   (clk),
      .reset (reset),
      .level (level[g]),
      .tick  (tick[g])
    );
  end

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] ev_id_q, ev_id_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] ovf_q, ovf_d;

  // Round-robin pick: scanning offsets high-to-low lets the nearest pending
  // channel after last_q overwrite any farther one.
  logic            sel_vld;
  logic [ID_W-1:0] sel_id;
  logic [ID_W-1:0] idx;

  always_comb begin
    sel_vld = 1'b0;
    sel_id  = '0;
    idx     = '0;
    for (int off = N_CH; off >= 1; off--) begin
      idx = ID_W'((int'(last_q) + off) % N_CH);
      if (pend_q[idx]) begin
        sel_vld = 1'b1;
        sel_id  = idx;
      end
    end
  end

  logic            hs;
  logic [N_CH-1:0] clr;
  logic [N_CH-1:0] ovf_set;

  always_comb begin
    hs  = (state_q == OFFER) && ev_ready;
    clr = '0;
    if (hs) clr[ev_id_q] = 1'b1;
    // A tick landing on its own handshake edge re-arms pending cleanly.
    ovf_set = tick & pend_q & ~clr;
    pend_d  = (pend_q & ~clr) | tick;
    ovf_d   = (ovf_q & ~ovf_clr) | ovf_set;
  end

  always_comb begin
    state_d = state_q;
    ev_id_d = ev_id_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          state_d = OFFER;
          ev_id_d = sel_id;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          state_d = IDLE;
          last_d  = ev_id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ev_id_q <= '0;
      last_q  <= ID_W'(N_CH - 1);
      pend_q  <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      ev_id_q <= ev_id_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ev_valid = (state_q == OFFER);
  assign ev_id    = ev_id_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Scoreboard bench for edge_event_arbiter: reference model predicts offers, monitor checks them.
module tb_edge_event_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  level;
  logic          ev_valid;
  logic          ev_ready;
  logic [IW-1:0] ev_id;
  logic [N-1:0]  overflow;
  logic [N-1:0]  ovf_clr;

  always #5 clk = ~clk;

  edge_event_arbiter #(.N_CH(N), .ID_W(IW)) dut (
    .clk      (clk),
    .reset    (reset),
    .level    (level),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_id    (ev_id),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: event-level bookkeeping from the rules, one update per edge.
  bit [N-1:0] m_pend, m_ovf, m_lastlow, m_tickd;
  int         m_lg, m_offer;
  int         expq[$];

  task automatic model_init();
    m_pend = '0; m_ovf = '0; m_lastlow = '0; m_tickd = '0;
    m_lg = N - 1; m_offer = -1;
    expq.delete();
  endtask

  task automatic model_step();
    bit         hs, clear;
    bit [N-1:0] p0;
    int         lg0, c;
    hs  = (m_offer >= 0) && ev_ready;
    p0  = m_pend;
    lg0 = m_lg;
    for (int i = 0; i < N; i++) begin
      clear = hs && (m_offer == i);
      if (m_tickd[i] && m_pend[i] && !clear) m_ovf[i] = 1'b1;
      else if (ovf_clr[i])                   m_ovf[i] = 1'b0;
      if (m_tickd[i])  m_pend[i] = 1'b1;
      else if (clear)  m_pend[i] = 1'b0;
      m_tickd[i]   = level[i] && m_lastlow[i];
      m_lastlow[i] = !level[i];
    end
    if (m_offer >= 0) begin
      if (hs) begin
        m_lg    = m_offer;
        m_offer = -1;
      end
    end else begin
      for (int off = 1; off <= N; off++) begin
        c = (lg0 + off) % N;
        if (p0[c]) begin
          m_offer = c;
          expq.push_back(c);
          break;
        end
      end
    end
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (!reset) model_step();
      #1;
    end
  endtask

  // Monitor: every cycle compares valid/overflow; each new offer pops an expected id.
  bit act_offer = 1'b0;
  int cur_exp   = -1;

  initial begin
    forever begin
      @(negedge clk);
      check("ev_valid", {31'd0, ev_valid}, {31'd0, (m_offer >= 0)});
      check("overflow", {28'd0, overflow}, {28'd0, m_ovf});
      if (ev_valid) begin
        if (!act_offer) begin
          if (expq.size() == 0) cur_exp = -1;
          else                  cur_exp = expq.pop_front();
          check("offer_id", {30'd0, ev_id}, cur_exp);
          act_offer = 1'b1;
        end else begin
          check("held_id", {30'd0, ev_id}, cur_exp);
        end
        if (ev_ready) act_offer = 1'b0;
      end else begin
        act_offer = 1'b0;
      end
    end
  end

  initial begin
    reset = 1'b1; level = '0; ev_ready = 1'b0; ovf_clr = '0;
    model_init();
    cyc(3);
    check("rst_valid", {31'd0, ev_valid}, 0);
    check("rst_id", {30'd0, ev_id}, 0);
    check("rst_ovf", {28'd0, overflow}, 0);
    reset = 1'b0;
    cyc(3);

    // Single event with explicit latency check
    ev_ready = 1'b1;
    level[2] = 1'b1;
    cyc(1);
    check("lat_k", {31'd0, ev_valid}, 0);
    cyc(1);
    check("lat_k1", {31'd0, ev_valid}, 0);
    cyc(1);
    check("lat_k2", {31'd0, ev_valid}, 1);
    check("lat_id", {30'd0, ev_id}, 2);
    cyc(1);
    check("lat_k3", {31'd0, ev_valid}, 0);
    level[2] = 1'b0;
    cyc(3);

    // Backpressure
    ev_ready = 1'b0;
    level[1] = 1'b1;
    cyc(23);
    ev_ready = 1'b1;
    cyc(3);
    level[1] = 1'b0;
    cyc(3);

    // Fairness: all rise together
    level = '1;
    cyc(12);
    level = '0;
    cyc(3);

    // Overflow on channel 3
    ev_ready = 1'b0;
    level[3] = 1'b1; cyc(2);
    level[3] = 1'b0; cyc(2);
    level[3] = 1'b1; cyc(2);
    level[3] = 1'b0; cyc(2);
    check("ovf3_set", {31'd0, overflow[3]}, 1);
    ev_ready = 1'b1;
    cyc(4);
    ovf_clr[3] = 1'b1; cyc(1);
    ovf_clr[3] = 1'b0; cyc(2);
    check("ovf3_clr", {31'd0, overflow[3]}, 0);

    // Collision: rise tick lands on the handshake edge of channel 2
    ev_ready = 1'b0;
    level[2] = 1'b1; cyc(1);
    level[2] = 1'b0; cyc(4);
    level[2] = 1'b1; cyc(1);
    ev_ready = 1'b1; cyc(1);
    cyc(4);
    check("coll_ovf2", {31'd0, overflow[2]}, 0);
    level[2] = 1'b0;
    cyc(3);

    // Reset mid-offer with level[0] held high
    ev_ready = 1'b0;
    level[0] = 1'b1;
    cyc(4);
    reset = 1'b1;
    model_init();
    #1;
    check("rst_mid_valid", {31'd0, ev_valid}, 0);
    cyc(2);
    reset = 1'b0;
    ev_ready = 1'b1;
    cyc(6);
    level[0] = 1'b0; cyc(1);
    level[0] = 1'b1; cyc(5);
    level[0] = 1'b0; cyc(2);

    // Randomized traffic
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) level[i] = ~level[i];
        ovf_clr[i] = ($urandom_range(7) == 0);
      end
      ev_ready = ($urandom_range(1) == 1);
      cyc(1);
    end

    // Drain
    level = '0; ovf_clr = '0; ev_ready = 1'b1;
    cyc(20);
    check("drain_q", expq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
